// File: rtl/seq_match_counter.sv
// rtl/seq_match_counter.sv - programmable LEN-symbol sequence detector with saturating hit counter
// SEQ_OVERLAP_EN: when defined, the suffix of one match may begin the next match.
module seq_match_counter #(
  parameter int W     = 2,
  parameter int LEN   = 3,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [W-1:0]           num,
  input  logic                   cfg_we,
  input  logic [$clog2(LEN)-1:0] cfg_idx,
  input  logic [W-1:0]           cfg_sym,
  input  logic                   sticky,
  input  logic                   clr,
  output logic                   hit,
  output logic                   ans,
  output logic [CNT_W-1:0]       hit_count
);

  localparam int FILL_W = $clog2(LEN + 1);

  // Slot 0 is the oldest symbol in time for both pattern and history.
  logic [LEN-1:0][W-1:0] pattern_q, pattern_d;
  logic [LEN-1:0][W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic                  hit_q, hit_d;
  logic                  latch_q, latch_d;
  logic                  ans_q, ans_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_comb begin
    pattern_d = pattern_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    hit_d     = 1'b0;
    if (cfg_we) begin
      if (int'(cfg_idx) < LEN) pattern_d[cfg_idx] = cfg_sym;
      fill_d = '0;
    end else if (in_valid) begin
      for (int i = 0; i < LEN - 1; i++) hist_d[i] = hist_q[i+1];
      hist_d[LEN-1] = num;
      if (fill_q != FILL_W'(LEN)) fill_d = fill_q + FILL_W'(1);
      hit_d = (fill_d == FILL_W'(LEN)) && (hist_d == pattern_q);
`ifdef SEQ_OVERLAP_EN
`else
      if (hit_d) fill_d = '0;
`endif
    end
  end

  // A latch taken while sticky stays held even if sticky later drops; only clr releases it.
  always_comb begin
    latch_d = clr ? 1'b0 : (latch_q | (sticky & hit_d));
    ans_d   = clr ? 1'b0 : (latch_d | hit_d);
    cnt_d   = cnt_q;
    if (clr)                      cnt_d = '0;
    else if (hit_d && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LEN; i++) pattern_q[i] <= W'(i + 1);
      hist_q  <= '0;
      fill_q  <= '0;
      hit_q   <= 1'b0;
      latch_q <= 1'b0;
      ans_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      hit_q     <= hit_d;
      latch_q   <= latch_d;
      ans_q     <= ans_d;
      cnt_q     <= cnt_d;
    end
  end

  assign hit       = hit_q;
  assign ans       = ans_q;
  assign hit_count = cnt_q;

endmodule

// File: tb/tb_seq_match_counter.sv
// tb/tb_seq_match_counter.sv - directed and random checks of seq_match_counter against a queue-based model
module tb_seq_match_counter;

  logic       clk = 1'b0;
  logic       reset, in_valid, cfg_we, sticky, clr;
  logic [1:0] num, cfg_idx, cfg_sym;
  logic       hit_a, ans_a, hit_b, ans_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int checks = 0;
  int errors = 0;
  int obs_hits = 0;

  // Reference state: pattern, accepted symbols since the last fill clear, expected outputs
  int pat[3];
  int q[$];
  int m_hit, m_ans, m_latch, m_cnt8, m_cnt2;

  always #5 clk = ~clk;

  seq_match_counter #(.W(2), .LEN(3), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .num(num),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sym(cfg_sym),
    .sticky(sticky), .clr(clr),
    .hit(hit_a), .ans(ans_a), .hit_count(cnt_a)
  );

  seq_match_counter #(.W(2), .LEN(3), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .num(num),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sym(cfg_sym),
    .sticky(sticky), .clr(clr),
    .hit(hit_b), .ans(ans_b), .hit_count(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_edge();
    int det;
    det = 0;
    if (reset) begin
      for (int i = 0; i < 3; i++) pat[i] = (i + 1) % 4;
      q.delete();
      m_hit = 0; m_ans = 0; m_latch = 0; m_cnt8 = 0; m_cnt2 = 0;
      return;
    end
    if (cfg_we) begin
      if (int'(cfg_idx) < 3) pat[int'(cfg_idx)] = int'(cfg_sym);
      q.delete();
    end else if (in_valid) begin
      q.push_back(int'(num));
      if (q.size() > 3) void'(q.pop_front());
      if (q.size() == 3 && q[0] == pat[0] && q[1] == pat[1] && q[2] == pat[2]) det = 1;
`ifdef SEQ_OVERLAP_EN
`else
      if (det == 1) q.delete();
`endif
    end
    m_hit = det;
    if (clr) begin
      m_cnt8 = 0; m_cnt2 = 0; m_latch = 0; m_ans = 0;
    end else begin
      if (det == 1 && m_cnt8 < 255) m_cnt8++;
      if (det == 1 && m_cnt2 < 3) m_cnt2++;
      if (sticky && det == 1) m_latch = 1;
      m_ans = m_latch | det;
    end
  endfunction

  task automatic step(input logic v, input logic [1:0] n, input logic we, input logic [1:0] idx,
                      input logic [1:0] sym, input logic cl, input logic rs);
    in_valid = v; num = n; cfg_we = we; cfg_idx = idx; cfg_sym = sym; clr = cl; reset = rs;
    @(posedge clk);
    model_edge();
    #1;
    if (hit_a === 1'b1) obs_hits++;
    chk("hit", hit_a, m_hit);
    chk("ans", ans_a, m_ans);
    chk("hit_count", cnt_a, m_cnt8);
    chk("hit_sat", hit_b, m_hit);
    chk("hit_count_sat", cnt_b, m_cnt2);
  endtask

  task automatic sym_in(input logic [1:0] n);
    step(1'b1, n, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [1:0] sym);
    step(1'b0, 2'd0, 1'b1, idx, sym, 1'b0, 1'b0);
  endtask

  task automatic pulse_clr();
    step(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
  endtask

  initial begin
    int h0;
    int sat_exp[5];
    logic v, we, cl, rs;
    logic [1:0] n, idx, sym;
    sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3; sat_exp[3] = 3; sat_exp[4] = 3;
    reset = 1'b1; in_valid = 1'b0; num = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_sym = '0;
    sticky = 1'b0; clr = 1'b0;

    step(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    step(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    chk("reset_hit", hit_a, 0);
    chk("reset_ans", ans_a, 0);
    chk("reset_count", cnt_a, 0);

    // default pattern, pulse mode
    sym_in(2'd1); sym_in(2'd2); sym_in(2'd3);
    chk("basic_hit", hit_a, 1);
    chk("basic_ans", ans_a, 1);
    chk("basic_count", cnt_a, 1);
    idle();
    chk("basic_hit_drop", hit_a, 0);
    chk("basic_ans_drop", ans_a, 0);

    // pattern 1,1,1 on 1,1,1,1
    cfg(2'd0, 2'd1); cfg(2'd1, 2'd1); cfg(2'd2, 2'd1);
    h0 = obs_hits;
    repeat (4) sym_in(2'd1);
`ifdef SEQ_OVERLAP_EN
    chk("overlap_hits", obs_hits - h0, 2);
    chk("overlap_count", cnt_a, 3);
`else
    chk("overlap_hits", obs_hits - h0, 1);
    chk("overlap_count", cnt_a, 2);
`endif
    cfg(2'd1, 2'd2); cfg(2'd2, 2'd3);

    // sticky latch and clear
    sticky = 1'b1;
    pulse_clr();
    sym_in(2'd1); sym_in(2'd2); sym_in(2'd3); sym_in(2'd0); sym_in(2'd0);
    chk("sticky_hold", ans_a, 1);
    pulse_clr();
    chk("clr_ans", ans_a, 0);
    chk("clr_count", cnt_a, 0);
    sym_in(2'd1); sym_in(2'd2); sym_in(2'd3);
    chk("sticky_reset", ans_a, 1);
    sticky = 1'b0;
    pulse_clr();

    // gaps and mismatches
    h0 = obs_hits;
    sym_in(2'd1); idle(); idle(); sym_in(2'd2); sym_in(2'd3);
    chk("gap_hit", obs_hits - h0, 1);
    h0 = obs_hits;
    sym_in(2'd1); sym_in(2'd2); sym_in(2'd0); sym_in(2'd3);
    chk("mismatch_none", obs_hits - h0, 0);
    h0 = obs_hits;
    sym_in(2'd3); sym_in(2'd1); sym_in(2'd2); sym_in(2'd3);
    chk("prefix_one", obs_hits - h0, 1);

    // narrow counter saturation
    pulse_clr();
    for (int k = 0; k < 5; k++) begin
      sym_in(2'd1); sym_in(2'd2); sym_in(2'd3);
      chk("sat_seq", cnt_b, sat_exp[k]);
      idle();
    end

    // cfg write drops a same-cycle symbol and breaks the sequence
    h0 = obs_hits;
    sym_in(2'd1); sym_in(2'd2);
    step(1'b1, 2'd3, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0);
    sym_in(2'd3);
    chk("cfg_drop", obs_hits - h0, 0);
    // out-of-range slot leaves the pattern alone but still clears fill
    sym_in(2'd1); sym_in(2'd2); cfg(2'd3, 2'd0); sym_in(2'd3);
    chk("cfg_oob", obs_hits - h0, 0);
    h0 = obs_hits;
    sym_in(2'd1); sym_in(2'd2); sym_in(2'd3);
    chk("cfg_oob_pattern", obs_hits - h0, 1);

    // reset mid-sequence, with a changed pattern restored by reset
    cfg(2'd2, 2'd0);
    h0 = obs_hits;
    sym_in(2'd1); sym_in(2'd2);
    step(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    sym_in(2'd3);
    chk("reset_break", obs_hits - h0, 0);
    sym_in(2'd1); sym_in(2'd2); sym_in(2'd3);
    chk("reset_pattern", obs_hits - h0, 1);

    // randomized traffic
    for (int ph = 0; ph < 4; ph++) begin
      sticky = ph[0];
      pulse_clr();
      for (int s = 0; s < 150; s++) begin
        v   = ($urandom_range(0, 9) < 7);
        n   = ($urandom_range(0, 1) == 1) ? 2'(pat[$urandom_range(0, 2)]) : 2'($urandom_range(0, 3));
        we  = ($urandom_range(0, 29) == 0);
        idx = 2'($urandom_range(0, 3));
        sym = 2'($urandom_range(0, 3));
        cl  = ($urandom_range(0, 39) == 0);
        rs  = ($urandom_range(0, 149) == 0);
        step(v, n, we, idx, sym, cl, rs);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_match_counter.md
Name: seq_match_counter

Overview:
- Parametrised successor to the fixed 3-symbol sequence FSM: detects a runtime-programmable pattern of LEN symbols, each W bits wide, on a qualified input stream.
- Counts detections, with a pulse or sticky result output.
- Sits beside the datapath as a pattern/event monitor; one clock domain.

Parameters:
- W, 2, symbol width in bits.
- LEN, 3, pattern length in symbols (≥2).
- CNT_W, 8, hit counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  qualifies num this cycle.
- num  in  W  input symbol.
- cfg_we  in  1  pattern write strobe.
- cfg_idx  in  $clog2(LEN)  pattern slot to write; 0 = first symbol in time.
- cfg_sym  in  W  symbol value written to slot cfg_idx.
- sticky  in  1  1 = ans latches after first hit; 0 = ans equals hit.
- clr  in  1  clears ans latch and hit_count.
- hit  out  1  one-cycle pulse per detection.
- ans  out  1  detection result (mode per sticky).
- hit_count  out  CNT_W  saturating count of detections.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values:
  - pattern[i] = (i+1) mod 2^W, i.e. 1,2,3 for the defaults.
  - history = 0; fill = 0; hit = 0; ans = 0; hit_count = 0.
- Reset asserted mid-operation discards partial sequences; no hit may straddle a reset.
- History:
  - Shift register of the last LEN accepted symbols plus a fill counter saturating at LEN.
  - A symbol is accepted only on an edge where in_valid=1 and cfg_we=0.
  - Cycles with in_valid=0 hold history and fill; gaps do not break a sequence.
- Match condition, evaluated on the post-update history at each accepting edge:
  - fill (after increment) == LEN, and
  - oldest..newest symbols equal pattern[0]..pattern[LEN-1].
- Latency:
  - hit is registered and goes high for exactly the cycle after the edge that accepted the final symbol.
  - hit is 0 in the cycle after any non-accepting edge.
- Counter:
  - hit_count increments by 1 per hit and saturates at 2^CNT_W-1 (no wrap).
- ans:
  - sticky=0: ans = hit (registered, same timing).
  - sticky=1: ans sets with hit and holds until clr or reset.
  - sticky may change at any time; a held latch persists until clr.
- Config:
  - cfg_we=1 writes pattern[cfg_idx] = cfg_sym and clears fill to 0, so no match spans a reprogram.
  - cfg_we has priority over in_valid; that cycle's num is dropped.
  - cfg_idx ≥ LEN: write ignored, but fill is still cleared.
- clr:
  - Clears the ans latch and hit_count; history and fill are untouched.
  - clr on the same edge as a detection: hit still pulses; clear wins, so hit_count=0 and ans=0.
- Overlap handling is selected by the optional feature below.

Optional Feature:
- Macro: SEQ_OVERLAP_EN.
- Defined: overlapping detection. History is kept after a hit, so a suffix of one match can start the next (pattern 1,1,1 on 1,1,1,1 gives 2 hits).
- Undefined: non-overlapping. fill is cleared to 0 on the detecting edge, so the next match needs LEN fresh accepted symbols (same stream gives 1 hit).

Test Plan:
- Reset, sticky=0, default pattern; feed valid 1,2,3 on consecutive edges -> hit=1 and ans=1 for one cycle after the 3rd edge; hit_count=1; both 0 the next cycle.
- Program pattern 1,1,1 via cfg_we (idx 0,1,2); feed 1,1,1,1 -> with SEQ_OVERLAP_EN, hits after the 3rd and 4th symbols, hit_count=2; without it, one hit, hit_count=1.
- Default pattern, sticky=1; feed 1,2,3,0,0 -> ans stays 1 through the 0s; pulse clr -> ans=0, hit_count=0 next cycle; a further 1,2,3 -> ans=1 again.
- Gaps and mismatch: 1, in_valid=0 for 2 cycles, 2, 3 -> hit; 1,2,0,3 -> no hit; 3,1,2,3 -> exactly one hit.
- Saturation: CNT_W=2; 5 separated 1,2,3 sequences -> hit_count reads 1,2,3,3,3.
- Disruptions:
  - Feed 1,2, then cfg_we write of idx0=1 with in_valid=1 and num=3 on the same edge, then 3 -> num dropped, no hit.
  - Feed 1,2, assert reset for 1 cycle, feed 3 -> no hit; pattern back to 1,2,3.
